// File: rtl/fifo_rd_unpack_32to16.sv
// Reads 32-bit words from an upstream FIFO under a credit limit, buffers them and
// emits each word as two 16-bit halves over a valid/ready stream.
module fifo_rd_unpack_32to16 #(
    parameter bit          LOW_FIRST = 1'b0,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        rd_clk_i,
    input  logic        sys_rst_n,
    input  logic        en_i,
    input  logic        fifo_empty_i,
    output logic        fifo_rd_en_o,
    input  logic [31:0] fifo_rdata_i,
    input  logic        fifo_rd_valid_i,
    output logic [15:0] m_data_o,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic [15:0] word_cnt_o,
    output logic        ovf_err_o
);

    localparam int unsigned PtrW = $clog2(BUF_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned SumW = PtrW + 2;

    logic [31:0]     buf_q [BUF_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] occ_q, occ_d;
    logic [CntW-1:0] infl_q, infl_d;
    logic            sel_q, sel_d;
    logic [15:0]     word_cnt_q, word_cnt_d;
    logic            ovf_q, ovf_d;
    logic [1:0]      arm_q;

    logic            push, pop, hs;
    logic [SumW-1:0] credit_used;
    logic [31:0]     head;
    logic [15:0]     first_half, second_half;

    always_comb begin
        head        = buf_q[rd_ptr_q];
        first_half  = LOW_FIRST ? head[15:0] : head[31:16];
        second_half = LOW_FIRST ? head[31:16] : head[15:0];
        m_valid_o   = (occ_q != '0);
        m_data_o    = sel_q ? second_half : first_half;
        word_cnt_o  = word_cnt_q;
        ovf_err_o   = ovf_q;

        // Data with no read outstanding is dropped and only flags the error.
        push        = fifo_rd_valid_i && (infl_q != '0);
        hs          = m_valid_o && m_ready_i;
        pop         = hs && sel_q;

        // Buffered words plus reads in flight may never exceed the buffer size.
        credit_used  = SumW'(occ_q) + SumW'(infl_q);
        fifo_rd_en_o = arm_q[1] && en_i && !fifo_empty_i &&
                       (credit_used < SumW'(BUF_DEPTH));
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        infl_d     = infl_q;
        sel_d      = sel_q;
        word_cnt_d = word_cnt_q;
        ovf_d      = ovf_q | (fifo_rd_valid_i && (infl_q == '0));

        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PtrW'(1);
            word_cnt_d = word_cnt_q + 16'd1;
        end
        if (hs) sel_d = ~sel_q;

        unique case ({push, pop})
            2'b10:   occ_d = occ_q + CntW'(1);
            2'b01:   occ_d = occ_q - CntW'(1);
            default: occ_d = occ_q;
        endcase

        unique case ({fifo_rd_en_o, push})
            2'b10:   infl_d = infl_q + CntW'(1);
            2'b01:   infl_d = infl_q - CntW'(1);
            default: infl_d = infl_q;
        endcase
    end

    always_ff @(posedge rd_clk_i or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            infl_q     <= '0;
            sel_q      <= 1'b0;
            word_cnt_q <= '0;
            ovf_q      <= 1'b0;
            arm_q      <= '0;
        end else begin
            if (push) buf_q[wr_ptr_q] <= fifo_rdata_i;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            infl_q     <= infl_d;
            sel_q      <= sel_d;
            word_cnt_q <= word_cnt_d;
            ovf_q      <= ovf_d;
            // Holds off reads for two edges after reset release.
            arm_q      <= {arm_q[0], 1'b1};
        end
    end

endmodule

// File: tb/tb_fifo_rd_unpack_32to16.sv
// Bench: upstream FIFO with fixed read latency, halfword-stream scoreboard for both
// halfword orders, plus literal checks for the directed scenarios.
module tb_fifo_rd_unpack_32to16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, empty, rd_en, rd_en1, rvalid, ready;
    logic [31:0] rdata;
    logic [15:0] data0, data1, wc0, wc1;
    logic        valid0, valid1, ovf0, ovf1;

    always #5 clk = ~clk;

    fifo_rd_unpack_32to16 #(.LOW_FIRST(1'b0), .BUF_DEPTH(2)) dut (
        .rd_clk_i(clk), .sys_rst_n(rst_n), .en_i(en), .fifo_empty_i(empty),
        .fifo_rd_en_o(rd_en), .fifo_rdata_i(rdata), .fifo_rd_valid_i(rvalid),
        .m_data_o(data0), .m_valid_o(valid0), .m_ready_i(ready),
        .word_cnt_o(wc0), .ovf_err_o(ovf0)
    );

    fifo_rd_unpack_32to16 #(.LOW_FIRST(1'b1), .BUF_DEPTH(2)) dut1 (
        .rd_clk_i(clk), .sys_rst_n(rst_n), .en_i(en), .fifo_empty_i(empty),
        .fifo_rd_en_o(rd_en1), .fifo_rdata_i(rdata), .fifo_rd_valid_i(rvalid),
        .m_data_o(data1), .m_valid_o(valid1), .m_ready_i(ready),
        .word_cnt_o(wc1), .ovf_err_o(ovf1)
    );

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          lat = 1;
    int          outst = 0;
    int          rd_cnt = 0;
    int          arrive_first = -1;
    int          post_rst = 0;
    bit          mdl_on = 0;
    bit          exp_ovf = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_data;
    logic [15:0] exp_wc = '0;
    logic [31:0] up_q[$];
    logic [15:0] exp0[$], exp1[$];
    logic [15:0] log0[$], log1[$];
    int          logc0[$];
    bit          pv[0:3];
    logic [31:0] pd[0:3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: compare at the falling edge, then update the upstream side.
    task automatic tick();
        logic [31:0] w;
        logic [15:0] h;
        @(negedge clk);
        if (mdl_on) begin
            if (post_rst > 0) begin
                chk("rd_en_after_reset", rd_en, 0);
                post_rst--;
            end
            chk("valid0", valid0, exp0.size() != 0);
            chk("valid1", valid1, exp1.size() != 0);
            chk("rd_en_same", rd_en1, rd_en);
            chk("word_cnt0", wc0, exp_wc);
            chk("word_cnt1", wc1, exp_wc);
            chk("ovf0", ovf0, exp_ovf);
            chk("ovf1", ovf1, exp_ovf);
            if (rd_en)
                chk("rd_en_legal", en && !empty && (outst + (exp0.size() + 1) / 2 < 2), 1);
            if (prev_stall && valid0) chk("stall_hold", data0, prev_data);
            if (valid0 && ready) begin
                h = (exp0.size() != 0) ? exp0.pop_front() : 16'hxxxx;
                chk("data0", data0, h);
                log0.push_back(data0);
                logc0.push_back(cyc);
                if (exp0.size() % 2 == 0) exp_wc++;
            end
            if (valid1 && ready) begin
                h = (exp1.size() != 0) ? exp1.pop_front() : 16'hxxxx;
                chk("data1", data1, h);
                log1.push_back(data1);
            end
            prev_stall = valid0 && !ready;
            prev_data  = data0;
            if (rvalid) begin
                if (outst > 0) begin
                    exp0.push_back(rdata[31:16]);
                    exp0.push_back(rdata[15:0]);
                    exp1.push_back(rdata[15:0]);
                    exp1.push_back(rdata[31:16]);
                    outst--;
                    if (arrive_first < 0) arrive_first = cyc;
                end else begin
                    exp_ovf = 1;
                end
            end
            if (rd_en) begin
                w = (up_q.size() != 0) ? up_q.pop_front() : 32'hxxxx_xxxx;
                pv[lat] = 1;
                pd[lat] = w;
                outst++;
                rd_cnt++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            pv[i] = pv[i+1];
            pd[i] = pd[i+1];
        end
        pv[3]  = 0;
        rvalid = pv[0];
        rdata  = pd[0];
        empty  = (up_q.size() == 0);
    endtask

    function automatic bit idle();
        return up_q.size() == 0 && outst == 0 && exp0.size() == 0 && !pv[0] && !pv[1] && !pv[2];
    endfunction

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!idle() && n < budget) begin
            tick();
            n++;
        end
        if (!idle()) begin
            failures++;
            checks++;
            $display("FAIL idle_timeout: got busy expected idle within %0d cycles", budget);
        end
    endtask

    task automatic load(input logic [31:0] w);
        up_q.push_back(w);
        empty = 0;
    endtask

    task automatic clear_logs();
        log0.delete();
        log1.delete();
        logc0.delete();
        arrive_first = -1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        mdl_on = 0;
        exp0.delete();
        exp1.delete();
        up_q.delete();
        outst = 0;
        exp_wc = '0;
        exp_ovf = 0;
        prev_stall = 0;
        for (int i = 0; i < 4; i++) pv[i] = 0;
        rvalid = 0;
        empty = 1;
        #2;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_valid", valid0, 0);
        chk("rst_data", data0, 16'h0000);
        chk("rst_word_cnt", wc0, 16'h0000);
        chk("rst_ovf", ovf0, 0);
        repeat (2) tick();
        rst_n = 1;
        mdl_on = 1;
        post_rst = 1;
    endtask

    initial begin
        int rd_before;
        rst_n = 0; en = 1; empty = 1; rvalid = 0; rdata = '0; ready = 1;
        for (int i = 0; i < 4; i++) begin
            pv[i] = 0;
            pd[i] = '0;
        end
        @(posedge clk);
        #1;
        do_reset();

        // S1: latency 1, two words, back-to-back halves
        clear_logs();
        load(32'h0001_0002);
        load(32'h0003_0004);
        wait_idle(50);
        chk("s1_count", log0.size(), 4);
        chk("s1_h0", log0[0], 16'h0001);
        chk("s1_h1", log0[1], 16'h0002);
        chk("s1_h2", log0[2], 16'h0003);
        chk("s1_h3", log0[3], 16'h0004);
        for (int i = 1; i < 4; i++) chk("s1_consecutive", logc0[i], logc0[0] + i);
        chk("s1_latency", logc0[0], arrive_first + 1);
        chk("s1_word_cnt", wc0, 16'd2);

        // S2: halfword order for both settings
        clear_logs();
        load(32'hAAAA_5555);
        wait_idle(50);
        chk("s2_low_first_h0", log1[0], 16'h5555);
        chk("s2_low_first_h1", log1[1], 16'hAAAA);
        chk("s2_high_first_h0", log0[0], 16'hAAAA);

        // S3: downstream stall, then drain with reads gated off
        clear_logs();
        ready = 0;
        for (int i = 0; i < 6; i++) load(32'h5000_0000 + 32'(i) * 32'h0001_0001);
        rd_cnt = 0;
        repeat (10) tick();
        chk("s3_reads_le_depth", rd_cnt <= 2, 1);
        en = 0;
        ready = 1;
        rd_before = rd_cnt;
        repeat (6) tick();
        chk("s3_en0_no_reads", rd_cnt, rd_before);
        en = 1;
        wait_idle(100);
        chk("s3_halves", log0.size(), 12);
        chk("s3_first", log0[0], 16'h5000);
        chk("s3_last", log0[11], 16'h0005);

        // S5: spurious read data sets the sticky error, stream continues
        rvalid = 1;
        rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        chk("s5_ovf_set", ovf0, 1);
        clear_logs();
        load(32'h1111_2222);
        wait_idle(50);
        chk("s5_h0", log0[0], 16'h1111);
        chk("s5_h1", log0[1], 16'h2222);
        chk("s5_ovf_held", ovf0, 1);

        // S6: reset after the first half of a word was accepted
        clear_logs();
        ready = 0;
        load(32'h1234_5678);
        for (int n = 0; n < 20 && !valid0; n++) tick();
        ready = 1;
        tick();
        ready = 0;
        chk("s6_first_half", log0[0], 16'h1234);
        do_reset();
        clear_logs();
        ready = 1;
        load(32'hCAFE_BEEF);
        wait_idle(50);
        chk("s6_after_h0", log0[0], 16'hCAFE);
        chk("s6_after_h1", log0[1], 16'hBEEF);
        chk("s6_word_cnt", wc0, 16'd1);

        // S4: latency 2, random ready, 1000 incrementing words
        do_reset();
        lat = 2;
        clear_logs();
        for (int i = 0; i < 1000; i++) load(32'(i) * 32'h0002_0003 + 32'h0100_0000);
        for (int n = 0; n < 20000 && !idle(); n++) begin
            ready = 1'($urandom_range(0, 1));
            tick();
        end
        ready = 1;
        wait_idle(50);
        chk("s4_halves", log0.size(), 2000);
        chk("s4_word_cnt", wc0, 16'd1000);
        chk("s4_ovf", ovf0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
